// File: rtl/pc_sequencer.sv
// Program-counter sequencer: start/done handshake, PC advance, PC-relative branches,
// stall and halt handling, and a saturating cycle counter for RUN cycles.
module pc_sequencer #(
  parameter int unsigned D  = 12,
  parameter int unsigned CW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [D-1:0]  i_start_addr,
  input  logic          i_stall,
  input  logic          i_branch_en,
  input  logic [D-1:0]  i_target,
  input  logic          i_halt,
  output logic [D-1:0]  o_prog_ctr,
  output logic          o_fetch_valid,
  output logic          o_done,
  output logic [CW-1:0] o_cycle_count
);

  typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

  state_e        r_state, w_state_next;
  logic [D-1:0]  r_pc, w_pc_next;
  logic [CW-1:0] r_cnt, w_cnt_next;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_pc    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      StIdle, StHalted: begin
        if (i_start) begin
          w_state_next = StRun;
          w_pc_next    = i_start_addr;
          w_cnt_next   = '0;
        end
      end
      StRun: begin
        // Every RUN cycle counts, including stalls and the halt cycle.
        if (r_cnt != '1) begin
          w_cnt_next = r_cnt + CW'(1);
        end
        if (i_halt) begin
          w_state_next = StHalted;
        end else if (i_stall) begin
          w_pc_next = r_pc;
        end else if (i_branch_en) begin
          // Unsigned add of the two's-complement offset gives the modulo-2^D result.
          w_pc_next = r_pc + i_target;
        end else begin
          w_pc_next = r_pc + D'(1);
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    o_fetch_valid = (r_state == StRun);
    o_done        = (r_state == StHalted);
    o_prog_ctr    = r_pc;
    o_cycle_count = r_cnt;
  end

endmodule
